// File: rtl/booth_seq_ctrl.sv
// Radix-2 Booth multiplier sequencer over an A:Q:Q-1 register, with optional byte-serial
// product streaming enabled by defining BOOTH_BYTE_OUT_EN.
module booth_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 byte_sel,
  output logic [7:0]           prod_byte,
  output logic                 byte_valid,
  input  logic                 byte_ready
);

  localparam int unsigned PW = 2 * WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    EVAL,
    SHIFT,
`ifdef BOOTH_BYTE_OUT_EN
    OUT_LO,
    OUT_HI,
`endif
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [WIDTH:0]   a_q, m_q, a_eval, a_sh;
  logic [WIDTH-1:0] q_q, q_sh;
  logic             qm1_q;
  logic [CNT_W-1:0] cnt_q, cnt_inc;
  logic             last_iter;

  logic             busy_d, done_d, byte_valid_d, byte_sel_d;
  logic [7:0]       prod_byte_d;

  // Booth add/sub on {Q0,Q-1} and the arithmetic right shift of A:Q:Q-1
  always_comb begin
    a_eval = a_q;
    case ({q_q[0], qm1_q})
      2'b10:   a_eval = a_q - m_q;
      2'b01:   a_eval = a_q + m_q;
      default: a_eval = a_q;
    endcase
    a_sh      = {a_q[WIDTH], a_q[WIDTH:1]};
    q_sh      = {a_q[0], q_q[WIDTH-1:1]};
    cnt_inc   = cnt_q + CNT_W'(1);
    last_iter = (cnt_inc == CNT_W'(WIDTH));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_d      = state_q;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    byte_valid_d = 1'b0;
    byte_sel_d   = 1'b0;
    prod_byte_d  = 8'd0;
    case (state_q)
      IDLE:  if (start) state_d = LOAD;
      LOAD:  state_d = EVAL;
      EVAL:  state_d = SHIFT;
      SHIFT: state_d = last_iter ? DONE : EVAL;
`ifdef BOOTH_BYTE_OUT_EN
      DONE:   state_d = OUT_LO;
      OUT_LO: if (byte_ready) state_d = OUT_HI;
      OUT_HI: if (byte_ready) state_d = IDLE;
`else
      DONE:   state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
`ifdef BOOTH_BYTE_OUT_EN
    byte_valid_d = (state_d == OUT_LO) || (state_d == OUT_HI);
    byte_sel_d   = (state_d == OUT_HI);
    if (state_d == OUT_LO)      prod_byte_d = product[7:0];
    else if (state_d == OUT_HI) prod_byte_d = product[15:8];
`endif
  end

`ifndef BOOTH_BYTE_OUT_EN
  logic unused_byte_ready;
  assign unused_byte_ready = byte_ready;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      byte_valid <= 1'b0;
      byte_sel   <= 1'b0;
      prod_byte  <= 8'd0;
    end else begin
      busy       <= busy_d;
      done       <= done_d;
      byte_valid <= byte_valid_d;
      byte_sel   <= byte_sel_d;
      prod_byte  <= prod_byte_d;
    end
  end

  // Datapath; product is captured on the final shift so it is valid while in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      product <= '0;
    end else begin
      case (state_q)
        LOAD: begin
          a_q   <= '0;
          m_q   <= {mcand[WIDTH-1], mcand};
          q_q   <= mplier;
          qm1_q <= 1'b0;
          cnt_q <= '0;
        end
        EVAL: a_q <= a_eval;
        SHIFT: begin
          a_q   <= a_sh;
          q_q   <= q_sh;
          qm1_q <= q_q[0];
          cnt_q <= cnt_inc;
          if (last_iter) product <= PW'({a_sh[WIDTH-1:0], q_sh});
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// Directed bench for booth_seq_ctrl; byte streaming checks are active when BOOTH_BYTE_OUT_EN
// is defined, otherwise the byte outputs are checked as tied low.
module tb_booth_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  mcand, mplier;
  logic        busy, done, byte_sel, byte_valid, byte_ready;
  logic [15:0] product;
  logic [7:0]  prod_byte;

  int n_cmp = 0;
  int n_err = 0;

  booth_seq_ctrl #(.WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mcand(mcand), .mplier(mplier),
    .busy(busy), .done(done), .product(product), .byte_sel(byte_sel),
    .prod_byte(prod_byte), .byte_valid(byte_valid), .byte_ready(byte_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a start (sampled at edge 0) and run until done or budget; cyc = cycle index reached.
  // pulse_at > 0 re-pulses start and scrambles operands in that cycle.
  task automatic launch(input logic [7:0] mc, input logic [7:0] mp, input int pulse_at,
                        input int stop_at, output int cyc);
    mcand = mc;
    mplier = mp;
    start = 1'b1;
    step();
    cyc = 1;
    start = 1'b0;
    while (done !== 1'b1 && cyc < 40 && cyc != stop_at) begin
      start = (cyc == pulse_at);
      if (cyc == pulse_at) begin
        mcand = ~mc;
        mplier = ~mp;
      end
      step();
      cyc++;
    end
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_idle"}, 32'(busy), 32'd0);
    step();
    step();
    check({tag, "_no_restart"}, 32'(busy), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [7:0] mc, input logic [7:0] mp,
                        input logic [15:0] exp, input int pulse_at);
    int cyc;
    launch(mc, mp, pulse_at, -1, cyc);
    check({tag, "_done_cycle"}, 32'(cyc), 32'd18);
    check({tag, "_product"}, 32'(product), 32'(exp));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    check({tag, "_valid_at_done"}, 32'(byte_valid), 32'd0);
    step();
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_product_hold"}, 32'(product), 32'(exp));
    wait_idle(tag);
  endtask

  initial begin
    int cyc;
    rst_n = 1'b0;
    start = 1'b0;
    mcand = 8'd0;
    mplier = 8'd0;
    byte_ready = 1'b1;
    step();
    step();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_prod_byte", 32'(prod_byte), 32'd0);
    rst_n = 1'b1;
    step();

    // 7 * -3 = -21
    run_op("t1", 8'd7, 8'hFD, 16'hFFEB, -1);
    // A start in cycle 6 is ignored and scrambled operands have no effect
    run_op("t5", 8'd7, 8'hFD, 16'hFFEB, 6);

    // Reset asserted during a SHIFT cycle
    launch(8'd7, 8'hFD, -1, 9, cyc);
    check("t6_reached_cycle", 32'(cyc), 32'd9);
    rst_n = 1'b0;
    step();
    check("t6_busy", 32'(busy), 32'd0);
    check("t6_product", 32'(product), 32'd0);
    check("t6_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    step();

    // -128 * -128 = 16384
    run_op("t2", 8'h80, 8'h80, 16'h4000, -1);
    run_op("t3a", 8'd127, 8'd127, 16'h3F01, -1);
    run_op("t3b", 8'd0, 8'hB3, 16'h0000, -1);
    // -1 * 1 = -1
    run_op("neg1", 8'hFF, 8'h01, 16'hFFFF, -1);

`ifdef BOOTH_BYTE_OUT_EN
    // Sink stalls for 5 cycles after done, then drains both bytes
    byte_ready = 1'b0;
    launch(8'd7, 8'hFD, -1, -1, cyc);
    check("t4_done_cycle", 32'(cyc), 32'd18);
    check("t4_valid_at_done", 32'(byte_valid), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_lo_valid", 32'(byte_valid), 32'd1);
      check("t4_lo_byte", 32'(prod_byte), 32'h00EB);
      check("t4_lo_sel", 32'(byte_sel), 32'd0);
      check("t4_lo_busy", 32'(busy), 32'd1);
      check("t4_lo_done", 32'(done), 32'd0);
    end
    byte_ready = 1'b1;
    step();
    check("t4_hi_valid", 32'(byte_valid), 32'd1);
    check("t4_hi_byte", 32'(prod_byte), 32'h00FF);
    check("t4_hi_sel", 32'(byte_sel), 32'd1);
    check("t4_hi_busy", 32'(busy), 32'd1);
    step();
    check("t4_end_busy", 32'(busy), 32'd0);
    check("t4_end_valid", 32'(byte_valid), 32'd0);
`else
    // Byte path absent: outputs stay low whatever byte_ready does
    byte_ready = 1'b0;
    launch(8'd7, 8'hFD, -1, -1, cyc);
    check("nb_done_cycle", 32'(cyc), 32'd18);
    step();
    check("nb_busy_after", 32'(busy), 32'd0);
    check("nb_valid", 32'(byte_valid), 32'd0);
    check("nb_sel", 32'(byte_sel), 32'd0);
    check("nb_byte", 32'(prod_byte), 32'd0);
    byte_ready = 1'b1;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
